muldiv_sequencer: RTL

- Multi-cycle controller and iterative datapath for the RV32M multiply/divide instructions in the execute stage.
- Accepts a request from EX when the decoded instruction is an M-extension op and holds the pipeline stalled while it iterates.
- Returns a one-cycle `done` with the 32-bit result, which EX muxes onto alu_data.
- Sits beside the single-cycle ALU, sharing its forwarded operands; the hazard unit ORs its stall into the front-end stall.

---
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] left_operand;
  logic [DATA_WIDTH-1:0] right_operand;
  logic                  flush;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  div_by_zero;

  modport master (
    output start, op, left_operand, right_operand, flush,
    input  stall, busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, left_operand, right_operand, flush,
    output stall, busy, done, result, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M MUL/MULH/DIV/REM unit: one shift-add or restoring-divide step per cycle,
// working on operand magnitudes and fixing the sign when the result is registered.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic            neg_left;
  logic            neg_right;
  logic [2*DW-1:0] acc;
  logic [DW-1:0]   operand_b;
  logic [CNT_W-1:0] counter;
  logic            busy_q;
  logic            done_q;
  logic [DW-1:0]   result_q;
  logic            dbz_q;

  logic [DW-1:0]   in_mag_left;
  logic [DW-1:0]   in_mag_right;
  logic            in_is_div;
  logic            in_div_zero;
  logic            in_overflow;
  logic            in_fast;
  logic [DW-1:0]   fast_value;

  logic [DW:0]     mul_sum;
  logic [2*DW-1:0] mul_next;
  logic [DW:0]     div_shift;
  logic            div_ok;
  logic [DW-1:0]   div_rem_sub;
  logic [2*DW-1:0] div_next;
  logic [2*DW-1:0] prod_signed;
  logic [DW-1:0]   quo_mag;
  logic [DW-1:0]   rem_mag;
  logic            sign_diff;
  logic [DW-1:0]   final_value;

  always_comb begin
    in_mag_left  = bus.left_operand[DW-1]  ? (~bus.left_operand  + DW'(1)) : bus.left_operand;
    in_mag_right = bus.right_operand[DW-1] ? (~bus.right_operand + DW'(1)) : bus.right_operand;
    in_is_div    = bus.op[1];
    in_div_zero  = (bus.right_operand == '0);
    in_overflow  = (bus.left_operand == {1'b1, {(DW-1){1'b0}}}) && (bus.right_operand == '1);
    in_fast      = in_is_div && (in_div_zero || in_overflow);
    if (bus.op[0]) begin
      fast_value = in_div_zero ? bus.left_operand : '0;
    end else begin
      fast_value = in_div_zero ? '1 : {1'b1, {(DW-1){1'b0}}};
    end
  end

  // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, quotient} there.
  always_comb begin
    mul_sum     = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, operand_b} : '0);
    mul_next    = {mul_sum, acc[DW-1:1]};
    div_shift   = {acc[2*DW-1:DW], acc[DW-1]};
    div_ok      = (div_shift >= {1'b0, operand_b});
    div_rem_sub = DW'(div_shift - {1'b0, operand_b});
    div_next    = {(div_ok ? div_rem_sub : div_shift[DW-1:0]), acc[DW-2:0], div_ok};
    sign_diff   = neg_left ^ neg_right;
    prod_signed = sign_diff ? -mul_next : mul_next;
    quo_mag     = div_next[DW-1:0];
    rem_mag     = div_next[2*DW-1:DW];
    case (op_q)
      2'd0:    final_value = prod_signed[DW-1:0];
      2'd1:    final_value = prod_signed[2*DW-1:DW];
      2'd2:    final_value = sign_diff ? -quo_mag : quo_mag;
      default: final_value = neg_left ? -rem_mag : rem_mag;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      neg_left  <= 1'b0;
      neg_right <= 1'b0;
      acc       <= '0;
      operand_b <= '0;
      counter   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          dbz_q  <= 1'b0;
          if (bus.start && !bus.flush) begin
            op_q      <= bus.op;
            neg_left  <= bus.left_operand[DW-1];
            neg_right <= bus.right_operand[DW-1];
            acc       <= {{DW{1'b0}}, (in_is_div ? in_mag_left : in_mag_right)};
            operand_b <= in_is_div ? in_mag_right : in_mag_left;
            counter   <= '0;
            busy_q    <= 1'b1;
            if (in_fast) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= fast_value;
              dbz_q    <= in_div_zero;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc     <= op_q[1] ? div_next : mul_next;
            counter <= counter + CNT_W'(1);
            if (counter == LAST_ITER) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= final_value;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          dbz_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall must drop in the same cycle as a flush or reset so the front end is released at once.
  assign bus.stall       = !reset && !bus.flush &&
                           (((state == IDLE) && bus.start) || (state == CALC));
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
endmodule
